// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 4;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_FRAME_BITS   = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset to 1 (idle line).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rx_s
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample in the same edge, forming a real two-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= async_in;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-cycle valid / frame_err pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t   state, state_next;
    logic             rx_s;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             half_done, bit_done;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (rx_in),
        .rx_s     (rx_s)
    );

    assign half_done = (bit_cnt == HALF_LAST);
    assign bit_done  = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (half_done) state_next = rx_s ? IDLE : DATA;
            DATA:  if (bit_done && idx == IDX_LAST) state_next = STOP;
            STOP:  if (bit_done) state_next = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: bit timing, shift register and the result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            idx       <= '0;
            shreg     <= '0;
            byte_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;

            if (state_next != state || state == IDLE || state == BREAK || bit_done)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (state == START)
                idx <= '0;

            if (state == DATA && bit_done) begin
                shreg[idx] <= rx_s;
                idx        <= idx + 3'd1;
            end

            if (state == STOP && bit_done) begin
                if (rx_s) begin
                    byte_out <= shreg;
                    valid    <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: a behavioural transmitter drives two receivers (4 and 8 clocks per bit).
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx4, rx8;
    logic [7:0] bo4, bo8;
    logic       v4, v8, fe4, fe8, b4, b8;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_bit;
        int         gap;
        bit         exp_err;
    } vec_t;

    exp_t       q4[$];
    exp_t       q8[$];
    logic [7:0] last_good [2];

    uart_receiver #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .reset(reset), .rx_in(rx4),
        .byte_out(bo4), .valid(v4), .frame_err(fe4), .busy(b4)
    );

    uart_receiver #(.CLKS_PER_BIT(8)) u8 (
        .clk(clk), .reset(reset), .rx_in(rx8),
        .byte_out(bo8), .valid(v8), .frame_err(fe8), .busy(b8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every pulse must match the oldest outstanding frame in kind, data and arrival cycle.
    task automatic mon(input bit s, input logic [7:0] bo, input logic v, input logic fe);
        exp_t e;
        if (v && fe) check("valid_and_frame_err_together", 1, 0);
        if (v || fe) begin
            if ((s ? q8.size() : q4.size()) == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse dut%0d: valid=%0b frame_err=%0b at cycle %0d, expected no pulse",
                         s ? 8 : 4, v, fe, cyc);
            end else begin
                e = s ? q8.pop_front() : q4.pop_front();
                check(s ? "pulse_is_err_8" : "pulse_is_err_4", 32'(fe), 32'(e.is_err));
                check(s ? "pulse_cycle_8" : "pulse_cycle_4", cyc, e.cyc);
                if (e.is_err) begin
                    check(s ? "byte_out_held_8" : "byte_out_held_4", 32'(bo), 32'(last_good[s]));
                end else begin
                    check(s ? "byte_out_8" : "byte_out_4", 32'(bo), 32'(e.data));
                    last_good[s] = e.data;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(1'b0, bo4, v4, fe4);
            mon(1'b1, bo8, v8, fe8);
        end
    end

    task automatic set_line(input bit s, input logic val);
        if (s) rx8 = val;
        else   rx4 = val;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input bit s, input logic val);
        set_line(s, val);
        idle(s ? 8 : 4);
    endtask

    // Called at posedge+1; the next posedge is the first one to sample the start bit.
    task automatic send_frame(input bit s, input logic [7:0] d, input bit stop_bit,
                              input bit exp_err, input bit expect_it);
        int   cpb;
        exp_t e;
        cpb      = s ? 8 : 4;
        e.is_err = exp_err;
        e.data   = d;
        e.cyc    = cyc + 3 + cpb / 2 + 9 * cpb;
        if (expect_it) begin
            if (s) q8.push_back(e);
            else   q4.push_back(e);
        end
        drive_bit(s, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(s, d[i]);
        drive_bit(s, stop_bit);
    endtask

    task automatic drain();
        int t = 0;
        while ((q4.size() != 0 || q8.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("outstanding_frames", q4.size() + q8.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   bc;

        vecs[0] = '{8'hA5, 1'b1, 20, 1'b0};
        vecs[1] = '{8'h00, 1'b1,  0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1,  0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 12, 1'b0};
        vecs[4] = '{8'hC3, 1'b0, 15, 1'b1};
        vecs[5] = '{8'h81, 1'b1,  3, 1'b0};
        vecs[6] = '{8'h7E, 1'b1,  9, 1'b0};

        reset = 1'b1;
        rx4   = 1'b1;
        rx8   = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        idle(3);
        @(negedge clk);
        check("reset_byte_out_4", 32'(bo4), 0);
        check("reset_valid_4", 32'(v4), 0);
        check("reset_frame_err_4", 32'(fe4), 0);
        check("reset_busy_4", 32'(b4), 0);
        check("reset_byte_out_8", 32'(bo8), 0);
        check("reset_busy_8", 32'(b8), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        // Table: loopback, back-to-back frames, an embedded framing error.
        for (int i = 0; i < 7; i++) begin
            send_frame(1'b0, vecs[i].data, vecs[i].stop_bit, vecs[i].exp_err, 1'b1);
            rx4 = 1'b1;
            idle(vecs[i].gap);
        end
        drain();
        idle(6);
        check("busy_after_table", 32'(b4), 0);

        // Single-clock glitch must be rejected at the half-bit check.
        rx4 = 1'b0;
        idle(1);
        rx4 = 1'b1;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (b4) bc++;
        end
        check("glitch_busy_at_most_half_plus_1", 32'(bc <= 3), 1);
        check("glitch_busy_seen", 32'(bc > 0), 1);
        @(posedge clk);
        #1;
        send_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b1);
        idle(4);
        drain();

        // Framing error then a held-low line: exactly one frame_err, nothing more until release.
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
        idle(30);
        check("break_busy_while_low", 32'(b4), 1);
        rx4 = 1'b1;
        idle(10);
        check("break_released_busy", 32'(b4), 0);
        send_frame(1'b0, 8'h12, 1'b1, 1'b0, 1'b1);
        idle(4);
        drain();

        // Reset during data bit 4 of 0xF0.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        rx4 = 1'b1;
        idle(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        @(negedge clk);
        check("midreset_busy", 32'(b4), 0);
        check("midreset_valid", 32'(v4), 0);
        check("midreset_byte_out", 32'(bo4), 0);
        @(posedge clk);
        #1;
        idle(24);
        check("midreset_still_idle", 32'(b4), 0);
        send_frame(1'b0, 8'h69, 1'b1, 1'b0, 1'b1);
        idle(4);
        drain();

        // Random bytes with random gaps (often zero) on both receivers.
        for (int i = 0; i < 30; i++) begin
            send_frame(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);
            idle($urandom_range(0, 1) ? 0 : $urandom_range(1, 15));
        end
        for (int i = 0; i < 200; i++) begin
            send_frame(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
            idle($urandom_range(0, 1) ? 0 : $urandom_range(1, 20));
        end
        idle(4);
        drain();
        idle(10);
        check("final_busy_8", 32'(b8), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
